gshare_predictor: RTL

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

---
 rtl/gshare_predictor.sv | 82 ++++++++
 1 files changed

// File: rtl/gshare_predictor.sv
// Gshare/bimodal branch direction predictor with saturating counters and registered prediction.
// Define GSHARE_EN to XOR global history into the index; undefined gives plain bimodal indexing.
module gshare_predictor #(
  parameter int unsigned CTR_W  = 2,
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned HIST_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [IDX_W-1:0]  req_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  output logic [HIST_W-1:0] hist
);

  localparam int unsigned Entries = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CtrMax  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CtrInit = {1'b0, {(CTR_W-1){1'b1}}};

  logic [CTR_W-1:0]  ctr_q [Entries];
  logic [HIST_W-1:0] hist_q, hist_d;
  logic [CTR_W-1:0]  upd_ctr_d;
  logic [CTR_W-1:0]  req_ctr;
  logic [IDX_W-1:0]  req_idx;
  logic              pred_valid_q, pred_taken_q;
  logic [IDX_W-1:0]  pred_idx_q;

`ifdef GSHARE_EN
  logic [HIST_W:0] hist_shift;

  always_comb begin
    hist_shift = {hist_q, upd_taken};
    hist_d     = upd_valid ? hist_shift[HIST_W-1:0] : hist_q;
    // Post-update history feeds the index so same-cycle updates are bypassed.
    req_idx    = req_pc ^ IDX_W'(hist_d);
  end
`else
  always_comb begin
    hist_d  = '0;
    req_idx = req_pc;
  end
`endif

  always_comb begin
    upd_ctr_d = ctr_q[upd_idx];
    if (upd_taken) begin
      if (upd_ctr_d != CtrMax) upd_ctr_d = upd_ctr_d + CTR_W'(1);
    end else begin
      if (upd_ctr_d != '0) upd_ctr_d = upd_ctr_d - CTR_W'(1);
    end
    req_ctr = (upd_valid && (upd_idx == req_idx)) ? upd_ctr_d : ctr_q[req_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < Entries; i++) ctr_q[i] <= CtrInit;
      hist_q       <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_idx_q   <= '0;
    end else begin
      if (upd_valid) ctr_q[upd_idx] <= upd_ctr_d;
      hist_q       <= hist_d;
      pred_valid_q <= req_valid;
      if (req_valid) begin
        pred_taken_q <= req_ctr[CTR_W-1];
        pred_idx_q   <= req_idx;
      end
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_idx   = pred_idx_q;
  assign hist       = hist_q;

endmodule
